// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM states, grant IDs, latency load helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_IO   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_IO  = 1'b1
  } grant_t;

  // Counter is loaded with MEM_LAT-1 so the final strobe cycle sees zero.
  function automatic logic [3:0] lat_load(input int unsigned lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Down-counter timing the length of one memory access; flags zero.
module mem_lat_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the main memory port between CPU and I/O; one access at a time, fixed latency.
// Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_wait_,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAT_LOAD = lat_load(MEM_LAT);

  state_t state_q, state_d;
  logic   cpu_elig, io_elig;
  logic   pick_cpu, pick_io;
  logic   start_cpu, start_io, finish;
  logic   lat_zero;

  // A requester whose done is pulsing this cycle is not re-granted.
  assign cpu_elig = cpu_req & ~cpu_done;
  assign io_elig  = io_req  & ~io_done;

`ifdef MEM_ARB_CPU_PRIO_EN
  assign pick_cpu = cpu_elig;
`else
  grant_t last_grant_q;

  assign pick_cpu = cpu_elig & (~io_elig | (last_grant_q == GNT_IO));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= GNT_IO;
    end else if (start_cpu) begin
      last_grant_q <= GNT_CPU;
    end else if (start_io) begin
      last_grant_q <= GNT_IO;
    end
  end
`endif

  assign pick_io = io_elig & ~pick_cpu;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_cpu = 1'b0;
    start_io  = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_cpu) begin
          start_cpu = 1'b1;
          state_d   = ST_CPU;
        end else if (pick_io) begin
          start_io = 1'b1;
          state_d  = ST_IO;
        end
      end
      ST_CPU, ST_IO: begin
        if (lat_zero) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_lat_counter u_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start_cpu | start_io),
    .load_val (LAT_LOAD),
    .dec      (state_q != ST_IDLE),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
      cpu_done  <= 1'b0;
      io_done   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      io_done  <= 1'b0;
      if (start_cpu) begin
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (start_io) begin
        mem_en    <= 1'b1;
        mem_we    <= io_we;
        mem_addr  <= io_addr;
        mem_wdata <= io_wdata;
      end
      if (finish) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (state_q == ST_CPU) begin
          cpu_done <= 1'b1;
          if (!mem_we) cpu_rdata <= mem_rdata;
        end else begin
          io_done <= 1'b1;
          if (!mem_we) io_rdata <= mem_rdata;
        end
      end
    end
  end

  assign cpu_wait_ = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural memory plus per-requester expectation queues.
module tb_mem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int LAT = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, io_req, io_we;
  logic [AW-1:0] cpu_addr, io_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, io_wdata, cpu_rdata, io_rdata, mem_wdata, mem_rdata;
  logic          cpu_done, io_done, cpu_wait_, mem_en, mem_we;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_wait_(cpu_wait_),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_done(io_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device and the bench's own view of its contents.
  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];
  assign mem_rdata = mem_en ? mem[mem_addr] : '0;
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  int   n_checks = 0;
  int   n_fail   = 0;
  bus_t cpu_bus_q[$], io_bus_q[$];
  logic [DW-1:0] cpu_exp_q[$], io_exp_q[$];
  logic [DW-1:0] cpu_last = '0, io_last = '0;
  bit   glog[$];
  bit   log_en = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT starts an access or pulses done.
  bus_t cur;
  bit   en_prev = 0, cdone_prev = 0, idone_prev = 0;
  int   en_len = 0;
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      chk("cpu_wait", 32'(cpu_wait_), 32'(cpu_req & ~cpu_done));
      if (mem_en && !en_prev) begin
        en_len = 1;
        if (mem_addr[8]) begin
          chk("io_bus_expected", 32'(io_bus_q.size() != 0), 32'd1);
          if (io_bus_q.size() != 0) cur = io_bus_q.pop_front();
        end else begin
          chk("cpu_bus_expected", 32'(cpu_bus_q.size() != 0), 32'd1);
          if (cpu_bus_q.size() != 0) cur = cpu_bus_q.pop_front();
        end
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
        if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
        if (log_en) glog.push_back(mem_addr[8]);
      end else if (mem_en) begin
        en_len++;
        chk("mem_addr_hold", 32'(mem_addr), 32'(cur.addr));
        chk("mem_we_hold", 32'(mem_we), 32'(cur.we));
      end else if (en_prev) begin
        chk("mem_en_len", 32'(en_len), 32'(LAT));
      end
      if (cpu_done) begin
        chk("cpu_done_pulse", 32'(cdone_prev), 32'd0);
        chk("cpu_done_expected", 32'(cpu_exp_q.size() != 0), 32'd1);
        if (cpu_exp_q.size() != 0) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
      end
      if (io_done) begin
        chk("io_done_pulse", 32'(idone_prev), 32'd0);
        chk("io_done_expected", 32'(io_exp_q.size() != 0), 32'd1);
        if (io_exp_q.size() != 0) chk("io_rdata", 32'(io_rdata), 32'(io_exp_q.pop_front()));
      end
    end
    en_prev    = mem_en;
    cdone_prev = cpu_done;
    idone_prev = io_done;
  end

  // CPU transactions use addresses with bit 8 clear, I/O with bit 8 set,
  // so expected read data does not depend on the interleaving.
  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int n;
    cpu_bus_q.push_back('{we, addr, wd});
    if (we) ref_mem[addr] = wd;
    else    cpu_last = ref_mem[addr];
    cpu_exp_q.push_back(cpu_last);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    n = 0;
    do begin
      step; n++;
      if (mem_en && !mem_addr[8] && !cpu_done) begin
        cpu_addr  = 12'($urandom) & 12'hEFF;
        cpu_wdata = 16'($urandom);
        cpu_we    = 1'($urandom);
      end
    end while (!cpu_done && n < 64);
    chk("cpu_within_bound", 32'(n < 64), 32'd1);
  endtask

  task automatic io_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int n;
    io_bus_q.push_back('{we, addr, wd});
    if (we) ref_mem[addr] = wd;
    else    io_last = ref_mem[addr];
    io_exp_q.push_back(io_last);
    io_we = we; io_addr = addr; io_wdata = wd; io_req = 1'b1;
    n = 0;
    do begin
      step; n++;
      if (mem_en && mem_addr[8] && !io_done) begin
        io_addr  = 12'($urandom) | 12'h100;
        io_wdata = 16'($urandom);
        io_we    = 1'($urandom);
      end
    end while (!io_done && n < 64);
    chk("io_within_bound", 32'(n < 64), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[12'h03A]     = 16'h8001;
    ref_mem[12'h03A] = 16'h8001;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;
    mon_en  = 1'b1;

    // Reset held with a CPU read pending, then first-grant timing.
    cpu_bus_q.push_back('{1'b0, 12'h03A, 16'h0000});
    cpu_last = 16'h8001;
    cpu_exp_q.push_back(cpu_last);
    cpu_addr = 12'h03A; cpu_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_cpu_done", 32'(cpu_done), 32'd0);
      chk("rst_io_done", 32'(io_done), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rdata", 32'({cpu_rdata, io_rdata}), 32'd0);
      chk("rst_cpu_wait", 32'(cpu_wait_), 32'd1);
    end
    reset_n = 1'b1;
    chk("t0_mem_en", 32'(mem_en), 32'd0);
    step;
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h03A);
    step;
    chk("t2_mem_en", 32'(mem_en), 32'd1);
    chk("t2_cpu_done", 32'(cpu_done), 32'd0);
    step;
    chk("t3_mem_en", 32'(mem_en), 32'd0);
    chk("t3_cpu_done", 32'(cpu_done), 32'd1);
    chk("t3_cpu_rdata", 32'(cpu_rdata), 32'h8001);
    chk("t3_cpu_wait", 32'(cpu_wait_), 32'd0);
    cpu_req = 1'b0;
    step;
    chk("t4_no_restart", 32'(mem_en), 32'd0);
    step;
    chk("t5_no_restart", 32'(mem_en), 32'd0);

    // I/O write then read-back.
    io_op(1'b1, 12'h100, 16'h1234);
    io_req = 1'b0;
    step;
    io_op(1'b0, 12'h100, 16'h0000);
    io_req = 1'b0;
    repeat (3) step;

    // Reset during the first strobe cycle of a CPU read.
    mon_en = 1'b0;
    cpu_we = 1'b0; cpu_addr = 12'h03A; cpu_req = 1'b1;
    step;
    chk("abort_t1_mem_en", 32'(mem_en), 32'd1);
    reset_n = 1'b0;
    step;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_cpu_done", 32'(cpu_done), 32'd0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    cpu_req = 1'b0;
    step;
    chk("abort_cpu_done2", 32'(cpu_done), 32'd0);
    reset_n = 1'b1;
    cpu_last = '0; io_last = '0;
    step;
    mon_en = 1'b1;

    // Both requesters continuously asserted: grants alternate, CPU first.
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) cpu_op(1'b0, 12'($urandom) & 12'hEFF, '0);
        cpu_req = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) io_op(1'b0, 12'($urandom) | 12'h100, '0);
        io_req = 1'b0;
      end
    join
    log_en = 1'b0;
    chk("grant_count", 32'(glog.size()), 32'd12);
    for (int i = 0; i < glog.size(); i++) chk("grant_order", 32'(glog[i]), 32'(i % 2));
    repeat (2) step;

    // Randomized mixed traffic with idle gaps.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          cpu_op(1'($urandom), 12'($urandom_range(0, 63)) & 12'hEFF, 16'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            cpu_req = 1'b0;
            repeat ($urandom_range(1, 3)) step;
          end
        end
        cpu_req = 1'b0;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          io_op(1'($urandom), 12'($urandom_range(0, 63)) | 12'h100, 16'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            io_req = 1'b0;
            repeat ($urandom_range(1, 3)) step;
          end
        end
        io_req = 1'b0;
      end
    join
    repeat (6) step;
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("cpu_queue_drained", 32'(cpu_exp_q.size() + cpu_bus_q.size()), 32'd0);
    chk("io_queue_drained", 32'(io_exp_q.size() + io_bus_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
